// File: rtl/accum_pkg.sv
// Shared types and helpers for the add/sub accumulator.
//   op_t    : operation encoding on the command stream (ADD, SUB, LOAD, READ)
//   state_t : clear-sweep FSM states (IDLE, SWEEP)
//   sat_max / sat_min : most positive / most negative two's complement value
//                       of a given width, returned sign-extended to 64 bits
package accum_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational operation unit for one accumulator update.
// Configuration macro: ACCUM_SAT_EN (defined: overflowing ADD/SUB clamp to the
// signed limits; undefined: they wrap modulo 2^WIDTH). ovf is reported either way.
// Ports:
//   op     in   op_t    operation
//   acc    in   WIDTH   current accumulator value
//   data   in   WIDTH   signed operand
//   result out  WIDTH   new accumulator value
//   ovf    out  1       signed overflow of ADD/SUB
module accum_alu
    import accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] ext_acc;
    logic [WIDTH:0] ext_data;
    logic [WIDTH:0] wide;

    assign ext_acc  = {acc[WIDTH-1], acc};
    assign ext_data = {data[WIDTH-1], data};

    always_comb begin
        wide   = '0;
        result = acc;
        ovf    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                wide = (op == OP_ADD) ? (ext_acc + ext_data) : (ext_acc - ext_data);
                // One guard bit: the result fits in WIDTH bits only when the
                // guard bit equals the WIDTH-bit sign bit.
                ovf    = wide[WIDTH] ^ wide[WIDTH-1];
                result = wide[WIDTH-1:0];
`ifdef ACCUM_SAT_EN
                // The guard bit carries the true sign of the exact result.
                if (ovf) begin
                    result = wide[WIDTH] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
                end
`endif
            end
            OP_LOAD: result = data;
            OP_READ: result = acc;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Multi-channel signed add/sub accumulator with a valid/ready command stream
// and a registered valid/ready result stream. clear_all starts a sweep that
// zeroes one channel per cycle.
// Configuration macro: ACCUM_SAT_EN (saturating ADD/SUB, see accum_alu).
// Handshake: a beat transfers on a rising edge where valid && ready; a source
// holds valid and its payload stable until that edge; ready never depends on
// the same-side valid.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake; in_op, in_ch, in_data payload
//   clear_all           request zeroing of all channels (wins over an op)
//   busy                clear sweep in progress
//   out_valid/out_ready result handshake; out_ch, out_data, out_ovf payload
//   dbg_state           current FSM state
module addsub_accumulator
    import accum_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear_all,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output state_t           dbg_state
);

    logic [WIDTH-1:0] acc [CHANNELS];
    state_t           state;
    logic [CH_W-1:0]  idx;

    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    // An op is taken only in IDLE, never alongside a clear request, and only
    // when the output register is empty or being drained this cycle.
    assign in_ready  = (state == ST_IDLE) && !clear_all && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state == ST_SWEEP);
    assign dbg_state = state;

    accum_alu #(.WIDTH(WIDTH)) u_alu (
        .op     (op_t'(in_op)),
        .acc    (acc[in_ch]),
        .data   (in_data),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // Accumulator array and clear-sweep FSM. Ops and sweep writes never
    // coincide because accept requires IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_all) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                    end else if (accept) begin
                        acc[in_ch] <= alu_result;
                    end
                end
                ST_SWEEP: begin
                    acc[idx] <= '0;
                    if (idx == CH_W'(CHANNELS - 1)) begin
                        state <= ST_IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: a new result overwrites a consumed one on the same
    // edge, so accept-and-consume gives no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= alu_result;
            out_ovf   <= alu_ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
